// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at accept, held as pending, and committed when the latency counter expires.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     pend_hi, pend_lo;
   logic                 pend_wr;
   logic                 accept;

   logic [2*WIDTH-1:0]   prod;
   logic                 neg_a, neg_b;
   logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, quo, rem;

   assign busy   = (cnt != '0);
   assign accept = start & ~busy & ~abort;

   // Division runs on magnitudes; signs are reapplied so that MIN / -1 wraps back to MIN.
   always_comb begin
      if (op == OP_MULT)
         prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      else
         prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      neg_a = (op == OP_DIV) & a[WIDTH-1];
      neg_b = (op == OP_DIV) & b[WIDTH-1];
      a_mag = neg_a ? -a : a;
      b_mag = neg_b ? -b : b;
      q_mag = '0;
      r_mag = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quo = (neg_a ^ neg_b) ? -q_mag : q_mag;
      rem = neg_a ? -r_mag : r_mag;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (abort) begin
               cnt     <= '0;
               pend_wr <= 1'b0;
            end else begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  done <= 1'b1;
                  if (pend_wr) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
               end
            end
         end else if (accept) begin
            case (op)
               OP_MULT, OP_MULTU: begin
                  pend_hi <= prod[2*WIDTH-1:WIDTH];
                  pend_lo <= prod[WIDTH-1:0];
                  pend_wr <= 1'b1;
                  cnt     <= CW'(MULT_CYCLES);
               end
               OP_DIV, OP_DIVU: begin
                  // Divide by zero still runs full latency but leaves HI/LO alone.
                  pend_hi <= rem;
                  pend_lo <= quo;
                  pend_wr <= (b != '0);
                  cnt     <= CW'(DIV_CYCLES);
               end
               OP_MTHI: hi <= a;
               OP_MTLO: lo <= a;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a 32-bit instance driven from a vector table plus hand
// sequences (ignore-while-busy, divide by zero, abort, reset) and an 8-bit instance for back-to-back timing.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;
   logic        busy, done;

   logic        start8, abort8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, hi8, lo8;
   logic        busy8, done8;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
      .hi(hi), .lo(lo), .busy(busy), .done(done));

   md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .abort(abort8),
      .hi(hi8), .lo(lo8), .busy(busy8), .done(done8));

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Issue a mult/div, check the busy window, completion cycle and the cycle after.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input string nm,
                         input bit inj);
      int n;
      n = (o <= 3'd2) ? 5 : 10;
      @(negedge clk); start = 1'b1; op = o; a = x; b = y;
      @(negedge clk); start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
      for (int i = 0; i < n; i++) begin
         if (inj && i == 1) begin start = 1'b1; op = 3'd6; a = 32'h1234; end
         chk({nm, " busy"}, 64'(busy), 64'd1);
         chk({nm, " hold"}, {hi, lo}, {m_hi, m_lo});
         @(negedge clk);
      end
      start = 1'b0; op = 3'd0;
      chk({nm, " done"}, {62'd0, busy, done}, 64'd1);
      chk({nm, " result"}, {hi, lo}, {ehi, elo});
      m_hi = ehi; m_lo = elo;
      @(negedge clk);
      chk({nm, " done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] x);
      @(negedge clk); start = 1'b1; op = o; a = x;
      @(negedge clk); start = 1'b0; op = 3'd0;
      if (o == 3'd5) m_hi = x; else m_lo = x;
      chk("mt busy/done", {62'd0, busy, done}, 64'd0);
      chk("mt result", {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      bit seen_done;
      vt[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vt[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
      vt[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vt[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vt[4] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vt[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vt[6] = '{3'd4, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999};
      vt[7] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};

      reset = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; a = '0; b = '0;
      start8 = 1'b0; abort8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      // start during reset must be overridden
      start = 1'b1; op = 3'd5; a = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("reset hi/lo", {hi, lo}, 64'd0);
      chk("reset busy/done", {62'd0, busy, done}, 64'd0);
      chk("reset8", {hi8, lo8, 6'd0, busy8, done8}, 64'd0);
      reset = 1'b1;

      foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, $sformatf("vec%0d", i), 1'b0);

      // mtlo during busy is ignored; mtlo afterwards applies
      run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, "divu ign", 1'b1);
      mt(3'd6, 32'h1234);

      // divide by zero keeps HI/LO
      mt(3'd5, 32'hAA);
      mt(3'd6, 32'hBB);
      run_op(3'd3, 32'd5, 32'd0, 32'hAA, 32'hBB, "div0", 1'b0);
      run_op(3'd4, 32'd9, 32'd0, 32'hAA, 32'hBB, "divu0", 1'b0);

      // abort in busy cycle 3 of a div
      @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk); start = 1'b0; op = 3'd0;
      @(negedge clk);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort busy/done", {62'd0, busy, done}, 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      chk("abort no done", 64'(seen_done), 64'd0);
      chk("abort hold", {hi, lo}, {m_hi, m_lo});

      // abort together with start while idle rejects the start
      @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h5555; abort = 1'b1;
      @(negedge clk); start = 1'b0; op = 3'd0; abort = 1'b0;
      chk("abort+start", {hi, lo, 31'd0, busy}, {m_hi, m_lo, 32'd0});

      // abort on the completing edge suppresses the write
      @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
      @(negedge clk); start = 1'b0; op = 3'd0;
      repeat (4) @(negedge clk);
      chk("last busy", 64'(busy), 64'd1);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort last busy/done", {62'd0, busy, done}, 64'd0);
      chk("abort last hold", {hi, lo}, {m_hi, m_lo});

      // reset mid-mult
      @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
      @(negedge clk); start = 1'b0; op = 3'd0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      m_hi = '0; m_lo = '0;
      chk("reset mid hi/lo", {hi, lo}, 64'd0);
      chk("reset mid busy/done", {62'd0, busy, done}, 64'd0);

      // 8-bit instance: mult 1 cycle, back-to-back div then divu on done cycles
      @(negedge clk); start8 = 1'b1; op8 = 3'd1; a8 = 8'h80; b8 = 8'h02;
      @(negedge clk); start8 = 1'b0; op8 = 3'd0;
      chk("w8 mult busy", {hi8, lo8, 7'd0, busy8}, {16'h0000, 8'd1});
      @(negedge clk);
      chk("w8 mult done", {hi8, lo8, 6'd0, busy8, done8}, {16'hFF00, 8'd1});
      start8 = 1'b1; op8 = 3'd3; a8 = 8'hF9; b8 = 8'h02;
      @(negedge clk); start8 = 1'b0; op8 = 3'd0;
      for (int i = 0; i < 3; i++) begin
         chk("w8 div busy", {hi8, lo8, 6'd0, busy8, done8}, {16'hFF00, 8'd2});
         @(negedge clk);
      end
      chk("w8 div done", {hi8, lo8, 6'd0, busy8, done8}, {16'hFFFD, 8'd1});
      start8 = 1'b1; op8 = 3'd4; a8 = 8'hC8; b8 = 8'h07;
      @(negedge clk); start8 = 1'b0; op8 = 3'd0;
      repeat (3) @(negedge clk);
      chk("w8 divu done", {hi8, lo8, 6'd0, busy8, done8}, {16'h041C, 8'd1});
      @(negedge clk);
      chk("w8 done pulse", 64'(done8), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
